// File: rtl/hart_mem_arbiter_pkg.sv
// Shared types and constants for the hart memory-port arbiter and its round-robin picker.
package hart_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam int DEFAULT_QUANTUM = 64;

  // Grant index width; a single hart still gets a 1-bit index so ports never collapse to zero width.
  function automatic int sel_width(input int n_harts);
    return (n_harts > 1) ? $clog2(n_harts) : 1;
  endfunction

endpackage

// File: rtl/hart_mem_arbiter_if.sv
// Request/grant bundle between the harts, the shared memory controller and the arbiter.
interface hart_mem_arbiter_if
  import hart_mem_arbiter_pkg::*;
#(
  parameter int N_HARTS = 2,
  parameter int SEL_W   = sel_width(N_HARTS),
  parameter int CNT_W   = 16
) ();

  logic [N_HARTS-1:0] w_req;
  logic [N_HARTS-1:0] w_rel;
  logic               w_mem_busy;
  logic               w_dram_busy;
  logic [N_HARTS-1:0] r_grant;
  logic [SEL_W-1:0]   r_sel;
  logic               r_grant_valid;
  logic [N_HARTS-1:0] w_hart_busy;
  logic [N_HARTS-1:0] w_hart_dram_busy;
  logic [CNT_W-1:0]   r_switch_cnt;

  modport slave (
    input  w_req, w_rel, w_mem_busy, w_dram_busy,
    output r_grant, r_sel, r_grant_valid, w_hart_busy, w_hart_dram_busy, r_switch_cnt
  );

  modport master (
    output w_req, w_rel, w_mem_busy, w_dram_busy,
    input  r_grant, r_sel, r_grant_valid, w_hart_busy, w_hart_dram_busy, r_switch_cnt
  );

endinterface

// File: rtl/hart_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping, with 'last' itself scanned last.
module hart_rr_pick
  import hart_mem_arbiter_pkg::*;
#(
  parameter int N_HARTS = 2,
  parameter int SEL_W   = sel_width(N_HARTS)
) (
  input  logic [N_HARTS-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N_HARTS);

  logic [2*N_HARTS-1:0] dbl;
  logic [N_HARTS-1:0]   rot;
  logic [SEL_W:0]       start;
  logic [SEL_W:0]       off;
  logic [SEL_W:0]       sum;

  // Rotating a doubled copy puts hart last+1 at bit 0, so a plain priority scan gives round-robin order.
  assign dbl   = {req, req};
  assign start = {1'b0, last} + 1'b1;
  assign rot   = N_HARTS'(dbl >> start);

  // NOTE: every output of a combinational block is given a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    any = 1'b0;
    off = '0;
    for (int k = N_HARTS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        off = (SEL_W + 1)'(k);
      end
    end
  end

  always_comb begin
    sum = start + off;
    if (sum >= N_EXT) sum = sum - N_EXT;
    idx = sum[SEL_W-1:0];
  end

endmodule

// File: rtl/hart_mem_arbiter.sv
// Shares one memory/MMU port among N_HARTS harts; ownership moves only at a hart safe boundary after the controller drains.
module hart_mem_arbiter
  import hart_mem_arbiter_pkg::*;
#(
  parameter int N_HARTS = 2,
  parameter int SEL_W   = sel_width(N_HARTS),
  parameter int QUANTUM = DEFAULT_QUANTUM,
  parameter int CNT_W   = 16
) (
  input logic                CLK,
  input logic                RST,
  hart_mem_arbiter_if.slave  bus
);

  localparam int Q_W = $clog2(QUANTUM + 1);

  arb_state_e         state_q, state_d;
  logic [N_HARTS-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   switch_cnt_q, switch_cnt_d;
  logic [Q_W-1:0]     quantum_q, quantum_d;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic               holder_rel;
  logic               holder_req;
  logic               others_req;
  logic               quantum_done;
  logic               ctrl_busy;

  hart_rr_pick #(
    .N_HARTS (N_HARTS),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req  (bus.w_req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // grant_q is onehot(sel_q) while owning, so masking with it selects the holder's bits.
  assign holder_rel   = |(bus.w_rel & grant_q);
  assign holder_req   = |(bus.w_req & grant_q);
  assign others_req   = |(bus.w_req & ~grant_q);
  assign quantum_done = (quantum_q == Q_W'(QUANTUM));
  assign ctrl_busy    = bus.w_mem_busy | bus.w_dram_busy;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    sel_d        = sel_q;
    last_d       = last_q;
    valid_d      = valid_q;
    switch_cnt_d = switch_cnt_q;
    quantum_d    = quantum_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d   = OWN;
          grant_d   = N_HARTS'(1) << pick_idx;
          sel_d     = pick_idx;
          last_d    = pick_idx;
          valid_d   = 1'b1;
          quantum_d = '0;
        end
      end

      OWN: begin
        if (others_req && !quantum_done) quantum_d = quantum_q + 1'b1;
        // A holder that re-requests at its boundary keeps the port unless its quantum is spent under contention.
        if (holder_rel && (!holder_req || (others_req && quantum_done))) begin
          state_d = DRAIN;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end

      DRAIN: begin
        if (!ctrl_busy) begin
          if (pick_any) begin
            state_d      = OWN;
            grant_d      = N_HARTS'(1) << pick_idx;
            sel_d        = pick_idx;
            last_d       = pick_idx;
            valid_d      = 1'b1;
            quantum_d    = '0;
            switch_cnt_d = switch_cnt_q + 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      sel_q        <= '0;
      last_q       <= SEL_W'(N_HARTS - 1);
      valid_q      <= 1'b0;
      switch_cnt_q <= '0;
      quantum_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      sel_q        <= sel_d;
      last_q       <= last_d;
      valid_q      <= valid_d;
      switch_cnt_q <= switch_cnt_d;
      quantum_q    <= quantum_d;
    end
  end

  assign bus.r_grant          = grant_q;
  assign bus.r_sel            = sel_q;
  assign bus.r_grant_valid    = valid_q;
  assign bus.r_switch_cnt     = switch_cnt_q;
  assign bus.w_hart_busy      = (grant_q & {N_HARTS{bus.w_mem_busy}})  | ~grant_q;
  assign bus.w_hart_dram_busy = (grant_q & {N_HARTS{bus.w_dram_busy}}) | ~grant_q;

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Self-checking bench: picker vector table, grant-order scoreboard, and cycle-exact arbiter sequences.
module tb_hart_mem_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  hart_mem_arbiter_if #(.N_HARTS(2), .SEL_W(1), .CNT_W(16)) a_if ();
  hart_mem_arbiter_if #(.N_HARTS(4), .SEL_W(2), .CNT_W(16)) b_if ();

  hart_mem_arbiter #(.N_HARTS(2), .SEL_W(1), .QUANTUM(4), .CNT_W(16)) dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (a_if)
  );

  hart_mem_arbiter #(.N_HARTS(4), .SEL_W(2), .QUANTUM(2), .CNT_W(16)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (b_if)
  );

  logic [3:0] p_req  = '0;
  logic [1:0] p_last = '0;
  logic       p_any;
  logic [1:0] p_idx;

  hart_rr_pick #(.N_HARTS(4), .SEL_W(2)) u_pick (
    .req  (p_req),
    .last (p_last),
    .any  (p_any),
    .idx  (p_idx)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: expected owner of each new grant, popped when r_grant_valid rises.
  int   qa[$];
  int   qb[$];
  logic prev_a_valid = 1'b0;
  logic prev_b_valid = 1'b0;

  always @(negedge CLK) begin
    if (a_if.r_grant_valid && !prev_a_valid) begin
      if (qa.size() == 0) begin
        n_total++;
        $display("FAIL sb_a_unexpected_grant: got sel %0d, expected no grant (t=%0t)", a_if.r_sel, $time);
      end else begin
        check("sb_a_grant_sel", 32'(a_if.r_sel), 32'(qa.pop_front()));
      end
    end
    if (b_if.r_grant_valid && !prev_b_valid) begin
      if (qb.size() == 0) begin
        n_total++;
        $display("FAIL sb_b_unexpected_grant: got sel %0d, expected no grant (t=%0t)", b_if.r_sel, $time);
      end else begin
        check("sb_b_grant_sel", 32'(b_if.r_sel), 32'(qb.pop_front()));
      end
    end
    prev_a_valid <= a_if.r_grant_valid;
    prev_b_valid <= b_if.r_grant_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] req;
    logic [1:0] last;
    logic       any;
    logic [1:0] idx;
  } pick_vec_t;

  pick_vec_t vecs[10];

  task automatic do_reset();
    RST = 1'b1;
    a_if.w_req = '0; a_if.w_rel = '0; a_if.w_mem_busy = 1'b0; a_if.w_dram_busy = 1'b0;
    b_if.w_req = '0; b_if.w_rel = '0; b_if.w_mem_busy = 1'b0; b_if.w_dram_busy = 1'b0;
    step();
    step();
    RST = 1'b0;
  endtask

  initial begin
    vecs[0] = '{req: 4'b0000, last: 2'd0, any: 1'b0, idx: 2'd0};
    vecs[1] = '{req: 4'b0001, last: 2'd3, any: 1'b1, idx: 2'd0};
    vecs[2] = '{req: 4'b1010, last: 2'd3, any: 1'b1, idx: 2'd1};
    vecs[3] = '{req: 4'b1010, last: 2'd1, any: 1'b1, idx: 2'd3};
    vecs[4] = '{req: 4'b1010, last: 2'd0, any: 1'b1, idx: 2'd1};
    vecs[5] = '{req: 4'b1111, last: 2'd2, any: 1'b1, idx: 2'd3};
    vecs[6] = '{req: 4'b1111, last: 2'd3, any: 1'b1, idx: 2'd0};
    vecs[7] = '{req: 4'b0100, last: 2'd2, any: 1'b1, idx: 2'd2};
    vecs[8] = '{req: 4'b1001, last: 2'd0, any: 1'b1, idx: 2'd3};
    vecs[9] = '{req: 4'b0110, last: 2'd2, any: 1'b1, idx: 2'd1};

    do_reset();

    // Reset state
    check("rst_a_grant",      32'(a_if.r_grant), 0);
    check("rst_a_sel",        32'(a_if.r_sel), 0);
    check("rst_a_valid",      32'(a_if.r_grant_valid), 0);
    check("rst_a_cnt",        32'(a_if.r_switch_cnt), 0);
    check("rst_a_hart_busy",  32'(a_if.w_hart_busy), 'h3);
    check("rst_a_dram_busy",  32'(a_if.w_hart_dram_busy), 'h3);
    check("rst_b_grant",      32'(b_if.r_grant), 0);
    check("rst_b_hart_busy",  32'(b_if.w_hart_busy), 'hf);

    // Picker vector table
    for (int i = 0; i < 10; i++) begin
      p_req  = vecs[i].req;
      p_last = vecs[i].last;
      #1;
      check($sformatf("pick_any[%0d]", i), 32'(p_any), 32'(vecs[i].any));
      if (vecs[i].any) check($sformatf("pick_idx[%0d]", i), 32'(p_idx), 32'(vecs[i].idx));
    end

    // Uncontended request, hold, release to IDLE
    a_if.w_rel = 2'b11;
    a_if.w_req = 2'b01;
    qa.push_back(0);
    step();
    check("u_grant",     32'(a_if.r_grant), 'h1);
    check("u_sel",       32'(a_if.r_sel), 0);
    check("u_valid",     32'(a_if.r_grant_valid), 1);
    check("u_hart_busy", 32'(a_if.w_hart_busy), 'h2);
    a_if.w_mem_busy = 1'b1;
    #1;
    check("u_hart_busy_mem", 32'(a_if.w_hart_busy), 'h3);
    a_if.w_mem_busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("u_hold_grant", 32'(a_if.r_grant), 'h1);
    end
    a_if.w_req = 2'b00;
    step();
    check("u_drain_valid", 32'(a_if.r_grant_valid), 0);
    check("u_drain_grant", 32'(a_if.r_grant), 0);
    check("u_drain_sel",   32'(a_if.r_sel), 0);
    step();
    a_if.w_req = 2'b10;
    qa.push_back(1);
    step();
    check("u_idle_regrant", 32'(a_if.r_grant), 'h2);
    check("u_idle_sel",     32'(a_if.r_sel), 1);
    check("u_idle_cnt",     32'(a_if.r_switch_cnt), 0);
    a_if.w_req = 2'b00;
    step();
    step();
    check("u_end_valid", 32'(a_if.r_grant_valid), 0);
    check("u_end_cnt",   32'(a_if.r_switch_cnt), 0);

    // Contended fair alternation, QUANTUM=4
    do_reset();
    a_if.w_rel = 2'b11;
    a_if.w_req = 2'b11;
    qa.push_back(0); qa.push_back(1); qa.push_back(0); qa.push_back(1);
    step();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 5; c++) begin
        check($sformatf("alt_hold[%0d]", r), 32'(a_if.r_grant), (r % 2 == 0) ? 'h1 : 'h2);
        if (c < 4) step();
      end
      step();
      check($sformatf("alt_drain_valid[%0d]", r), 32'(a_if.r_grant_valid), 0);
      check($sformatf("alt_drain_grant[%0d]", r), 32'(a_if.r_grant), 0);
      step();
      check($sformatf("alt_cnt[%0d]", r), 32'(a_if.r_switch_cnt), 32'(r + 1));
    end
    check("alt_last_grant", 32'(a_if.r_grant), 'h2);
    a_if.w_req = 2'b00;
    step();
    step();

    // No preemption without a safe boundary
    do_reset();
    a_if.w_req = 2'b11;
    a_if.w_rel = 2'b10;
    qa.push_back(0);
    step();
    for (int i = 0; i < 100; i++) begin
      step();
      check("nopre_hold", 32'(a_if.r_grant), 'h1);
    end
    a_if.w_rel = 2'b11;
    step();
    check("nopre_drain", 32'(a_if.r_grant_valid), 0);
    qa.push_back(1);
    step();
    check("nopre_switch_grant", 32'(a_if.r_grant), 'h2);
    check("nopre_switch_sel",   32'(a_if.r_sel), 1);
    check("nopre_switch_cnt",   32'(a_if.r_switch_cnt), 1);
    a_if.w_req = 2'b00;
    step();
    step();

    // Drain wait on mem busy, dram busy, then reset mid-DRAIN
    do_reset();
    a_if.w_req = 2'b11;
    a_if.w_rel = 2'b11;
    qa.push_back(0);
    step();
    a_if.w_mem_busy = 1'b1;
    #1;
    check("dw_own_hart_busy", 32'(a_if.w_hart_busy), 'h3);
    for (int c = 1; c < 5; c++) begin
      step();
      check("dw_own_grant", 32'(a_if.r_grant), 'h1);
    end
    step();
    for (int i = 0; i < 7; i++) begin
      check("dw_drain_valid", 32'(a_if.r_grant_valid), 0);
      check("dw_drain_busy",  32'(a_if.w_hart_busy), 'h3);
      if (i < 6) step();
    end
    a_if.w_mem_busy = 1'b0;
    qa.push_back(1);
    step();
    check("dw_new_grant", 32'(a_if.r_grant), 'h2);
    check("dw_new_cnt",   32'(a_if.r_switch_cnt), 1);
    a_if.w_dram_busy = 1'b1;
    #1;
    check("dw_dram_busy_on",  32'(a_if.w_hart_dram_busy), 'h3);
    a_if.w_dram_busy = 1'b0;
    #1;
    check("dw_dram_busy_off", 32'(a_if.w_hart_dram_busy), 'h1);
    a_if.w_dram_busy = 1'b1;
    for (int c = 1; c < 5; c++) begin
      step();
      check("dw_own1_grant", 32'(a_if.r_grant), 'h2);
    end
    step();
    check("dw_dram_drain_valid", 32'(a_if.r_grant_valid), 0);
    check("dw_dram_drain_sel",   32'(a_if.r_sel), 1);
    step();
    check("dw_dram_hold_valid",  32'(a_if.r_grant_valid), 0);
    RST = 1'b1;
    step();
    check("rd_grant", 32'(a_if.r_grant), 0);
    check("rd_sel",   32'(a_if.r_sel), 0);
    check("rd_valid", 32'(a_if.r_grant_valid), 0);
    check("rd_cnt",   32'(a_if.r_switch_cnt), 0);
    RST = 1'b0;
    a_if.w_dram_busy = 1'b0;
    qa.push_back(0);
    step();
    check("rd_first_grant", 32'(a_if.r_grant), 'h1);
    a_if.w_req = 2'b00;
    step();
    step();

    // N_HARTS=4, QUANTUM=2: hart 3 owns, then 1010 picks 1 before 3
    b_if.w_rel = 4'b1111;
    b_if.w_req = 4'b1000;
    qb.push_back(3);
    step();
    check("b_first_grant", 32'(b_if.r_grant), 'h8);
    check("b_first_sel",   32'(b_if.r_sel), 3);
    b_if.w_req = 4'b1010;
    qb.push_back(1);
    qb.push_back(3);
    step();
    check("b_hold3_a", 32'(b_if.r_grant), 'h8);
    step();
    check("b_hold3_b", 32'(b_if.r_grant), 'h8);
    step();
    check("b_drain0", 32'(b_if.r_grant_valid), 0);
    step();
    check("b_grant1",  32'(b_if.r_grant), 'h2);
    check("b_sel1",    32'(b_if.r_sel), 1);
    check("b_cnt1",    32'(b_if.r_switch_cnt), 1);
    step();
    step();
    check("b_hold1", 32'(b_if.r_grant), 'h2);
    step();
    check("b_drain1", 32'(b_if.r_grant_valid), 0);
    step();
    check("b_grant3", 32'(b_if.r_grant), 'h8);
    check("b_sel3",   32'(b_if.r_sel), 3);
    check("b_cnt2",   32'(b_if.r_switch_cnt), 2);
    b_if.w_req = 4'b0000;
    step();
    step();
    check("b_end_valid", 32'(b_if.r_grant_valid), 0);

    step();
    check("sb_a_empty", 32'(qa.size()), 0);
    check("sb_b_empty", 32'(qb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hart_mem_arbiter.md
Name: hart_mem_arbiter

Overview:
- Shares the single memory/MMU port of the cluster among N_HARTS cores.
- Grants one hart at a time. Ownership changes only at a hart-declared safe boundary (pipeline idle, no CSR op in flight) and only after the memory controller has drained.
- Uses round-robin fairness with a cycle quantum, so one hart cannot starve the others.
- The grant index drives the cluster output muxes. Per-hart busy outputs hold every non-owner stalled.

Parameters:
- N_HARTS, 2, number of requesting harts (>=1).
- SEL_W, (N_HARTS>1 ? $clog2(N_HARTS) : 1), width of the grant index.
- QUANTUM, 64, minimum ownership cycles before a contended switch is allowed (>=1).
- CNT_W, 16, width of the switch statistics counter.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- w_req  in  N_HARTS  hart g wants the memory port.
- w_rel  in  N_HARTS  hart g is at a safe switch boundary: next_state idle, no CSR in EX/MEM, instruction taken.
- w_mem_busy  in  1  shared memory controller busy.
- w_dram_busy  in  1  shared DRAM busy, as seen by the MMU page walker.
- r_grant  out  N_HARTS  one-hot grant; all zero when no hart owns the port.
- r_sel  out  SEL_W  index of the owning hart; holds its last value when r_grant_valid=0.
- r_grant_valid  out  1  some hart owns the port.
- w_hart_busy  out  N_HARTS  per-hart busy = (r_grant[g] ? w_mem_busy : 1).
- w_hart_dram_busy  out  N_HARTS  per-hart DRAM busy = (r_grant[g] ? w_dram_busy : 1).
- r_switch_cnt  out  CNT_W  number of completed ownership transfers; wraps modulo 2^CNT_W.

Behaviour:
- Reset: r_grant=0, r_sel=0, r_grant_valid=0, r_switch_cnt=0, state=IDLE, quantum counter=0, round-robin pointer last=N_HARTS-1, so hart 0 has first priority. Reset asserted mid-transfer aborts immediately. Reset has no effect on the busy outputs beyond r_grant=0, so all w_hart_busy=1 after reset.
- Pick function: first g with w_req[g]=1, scanning last+1, last+2, ... mod N_HARTS. The previous owner is scanned last.
- IDLE:
  - If any w_req is set, on the next edge: state=OWN, r_grant=onehot(pick), r_sel=pick, r_grant_valid=1, last=pick, quantum counter=0.
  - Latency from request to grant is 1 cycle.
- OWN:
  - Quantum counter increments while any other hart requests; it saturates at QUANTUM.
  - Holder finished: if w_rel[sel]=1 and w_req[sel]=0, go to DRAIN.
  - Preemption: if w_rel[sel]=1, another hart requests, and the counter equals QUANTUM, go to DRAIN.
  - If w_rel[sel]=0, stay in OWN regardless of the counter. No preemption ever happens mid-instruction.
- DRAIN:
  - On entry: r_grant=0, r_grant_valid=0, and r_sel holds.
  - Remain in DRAIN while w_mem_busy=1 or w_dram_busy=1.
  - When both are 0 and a requester exists: state=OWN, grant pick, r_switch_cnt++, and the quantum counter clears.
  - When both are 0 and there are no requests: state=IDLE.
  - DRAIN lasts at least 1 cycle.
- Single hart (N_HARTS=1): the preemption path never fires. Grant asserts on request and releases on w_rel & !w_req.
- Simultaneous events: w_rel and a new w_req from the same holder in the same cycle means the holder keeps the grant. No transition occurs unless the preemption condition holds.
- Invariants:
  - r_grant is one-hot or zero.
  - r_grant != 0 implies r_grant_valid=1, and r_grant = onehot(r_sel).
  - w_req, w_rel and the busy inputs are sampled only at the clock edge; w_hart_busy and w_hart_dram_busy are combinational from registered grants.

Decomposition:
- Shared package holds:
  - state localparams IDLE=2'd0, OWN=2'd1, DRAIN=2'd2;
  - the SEL_W computation function;
  - the default QUANTUM.
- One sub-module: hart_rr_pick. It is a combinational round-robin priority picker with inputs req[N] and last[SEL_W], and outputs any and idx[SEL_W]. It is reused by future interrupt or cache arbiters.

Test Plan:
- Request without contention: N=2; at cycle 5 w_req=01 with w_rel tied 1 -> at cycle 6 r_grant=01, r_sel=0, w_hart_busy[1]=1. At cycle 10 w_req=00 -> DRAIN, then IDLE with w_grant_valid=0. r_switch_cnt stays 0.
- Contended, fair alternation: both requesting continuously, w_rel=11, QUANTUM=4 -> grants alternate 01, 10, 01. Each ownership lasts 5 cycles plus a 1-cycle DRAIN gap. r_switch_cnt increments on each transfer.
- No preemption without a safe boundary: contended, w_rel[0]=0 for 100 cycles -> hart 0 keeps r_grant=01 for all 100 cycles. The switch occurs 1 cycle after w_rel[0] rises.
- Drain wait: preempt while w_mem_busy=1 for 7 cycles -> r_grant_valid=0 for all 7 cycles. The new grant appears the edge after w_mem_busy falls. w_hart_busy=11 throughout.
- Reset mid-DRAIN: RST=1 for 1 cycle -> next cycle r_grant=0, r_sel=0, state IDLE. After release, the first grant goes to hart 0 when both harts request.
- N_HARTS=4, requests 1010 after hart 3 owned -> pick order 1, then 3. Hart 3 is last in the scan, so it wins only after hart 1.
